// File: rtl/fb_scanout.sv
// fb_scanout -- read side of the 256x256 framebuffer.
//
// Generates 640x480@60 VGA-style timing and centres the 256x256 window in
// the active area. Inside the window it issues read addresses {Y,X} to the
// framebuffer RAM. It drives the returned 9-bit pixel to the DAC pins,
// aligned with HSYNC/VSYNC/DE.
//
// Ports
//   CLK          in   pixel clock, rising edge
//   RST          in   asynchronous reset, active-high
//   RADDR        out  [15:0] framebuffer read address {Y[7:0],X[7:0]}
//   RDATA        in   [8:0]  read data {R,G,B}, valid RD_LAT cycles after RADDR
//   BORDER       in   [8:0]  border colour {R,G,B} (only with FB_BORDER_EN)
//   HSYNC/VSYNC  out  active-low syncs
//   DE           out  display enable (640x480 active area)
//   R, G, B      out  [2:0] pixel colour
//   VBLANK_START out  one-cycle pulse at the first blanking line
//   FRAME_CNT    out  [7:0] frame counter (not delayed)
//
// Build option: define FB_BORDER_EN to add the BORDER input. Active pixels
// outside the window then show BORDER instead of black.
//
// RD_LAT must lie in 1..4. All pin outputs lag the scan counters by
// RD_LAT+1 cycles.
module fb_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int WIN_X0   = 192,
   parameter int WIN_Y0   = 112,
   parameter int RD_LAT   = 1
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [15:0] RADDR,
   input  logic [8:0]  RDATA,
`ifdef FB_BORDER_EN
   input  logic [8:0]  BORDER,
`endif
   output logic        HSYNC,
   output logic        VSYNC,
   output logic        DE,
   output logic [2:0]  R,
   output logic [2:0]  G,
   output logic [2:0]  B,
   output logic        VBLANK_START,
   output logic [7:0]  FRAME_CNT
);

   localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
   localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
   localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] WX0_C    = 10'(WIN_X0);
   localparam logic [9:0] WY0_C    = 10'(WIN_Y0);

   logic [9:0]      hcnt_q, hcnt_d;
   logic [9:0]      vcnt_q, vcnt_d;
   logic [7:0]      frame_q, frame_d;
   logic [15:0]     raddr_q, raddr_d;
   logic [RD_LAT:0] act_dly_q, act_dly_d;
   logic [RD_LAT:0] hs_dly_q, hs_dly_d;
   logic [RD_LAT:0] vs_dly_q, vs_dly_d;
   logic [RD_LAT:0] win_dly_q, win_dly_d;
   logic [RD_LAT:0] vb_dly_q, vb_dly_d;
   logic [8:0]      rgb_q, rgb_d;

   logic            act_s, hs_s, vs_s, win_s, vb_s;
   logic [8:0]      border_s;

   // The window test uses a 10-bit offset; its top two bits being zero
   // means the position lies within 256 of the window origin.
   function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
      logic [9:0] dx;
      logic [9:0] dy;
      dx = h - WX0_C;
      dy = v - WY0_C;
      return (h < H_ACT_C) && (v < V_ACT_C) &&
             (h >= WX0_C) && (v >= WY0_C) &&
             (dx[9:8] == 2'b00) && (dy[9:8] == 2'b00);
   endfunction

   // Next-state of the raster counters and the frame counter.
   always_comb begin
      hcnt_d  = hcnt_q + 10'd1;
      vcnt_d  = vcnt_q;
      frame_d = frame_q;
      if (hcnt_q == H_LAST_C) begin
         hcnt_d = 10'd0;
         if (vcnt_q == V_LAST_C) begin
            vcnt_d  = 10'd0;
            frame_d = frame_q + 8'd1;
         end else begin
            vcnt_d = vcnt_q + 10'd1;
         end
      end else begin
         hcnt_d = hcnt_q + 10'd1;
      end
   end

   // Stage-0 attributes of the pixel the counters currently point at.
   always_comb begin
      act_s = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
      hs_s  = !((hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C));
      vs_s  = !((vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C));
      win_s = in_window(hcnt_q, vcnt_q);
      vb_s  = (hcnt_q == 10'd0) && (vcnt_q == V_ACT_C);
   end

   // Read address is computed from the next counter values so that RADDR
   // changes on the same edge as the counters and names the current pixel.
   always_comb begin
      if (in_window(hcnt_d, vcnt_d)) begin
         raddr_d = {8'(vcnt_d - WY0_C), 8'(hcnt_d - WX0_C)};
      end else begin
         raddr_d = raddr_q;
      end
   end

   // Delay line shift and output colour selection.
   always_comb begin
      act_dly_d = {act_dly_q[RD_LAT-1:0], act_s};
      hs_dly_d  = {hs_dly_q[RD_LAT-1:0], hs_s};
      vs_dly_d  = {vs_dly_q[RD_LAT-1:0], vs_s};
      win_dly_d = {win_dly_q[RD_LAT-1:0], win_s};
      vb_dly_d  = {vb_dly_q[RD_LAT-1:0], vb_s};
`ifdef FB_BORDER_EN
      border_s = BORDER;
`else
      border_s = 9'd0;
`endif
      // Tap RD_LAT-1 lines up with RDATA for the same pixel; the final
      // stage and rgb_q then become the pins together.
      if (win_dly_q[RD_LAT-1]) begin
         rgb_d = RDATA;
      end else if (act_dly_q[RD_LAT-1]) begin
         rgb_d = border_s;
      end else begin
         rgb_d = 9'd0;
      end
   end

   // State registers with asynchronous reset to the inactive values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hcnt_q    <= 10'd0;
         vcnt_q    <= 10'd0;
         frame_q   <= 8'd0;
         raddr_q   <= 16'd0;
         act_dly_q <= {(RD_LAT+1){1'b0}};
         hs_dly_q  <= {(RD_LAT+1){1'b1}};
         vs_dly_q  <= {(RD_LAT+1){1'b1}};
         win_dly_q <= {(RD_LAT+1){1'b0}};
         vb_dly_q  <= {(RD_LAT+1){1'b0}};
         rgb_q     <= 9'd0;
      end else begin
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         frame_q   <= frame_d;
         raddr_q   <= raddr_d;
         act_dly_q <= act_dly_d;
         hs_dly_q  <= hs_dly_d;
         vs_dly_q  <= vs_dly_d;
         win_dly_q <= win_dly_d;
         vb_dly_q  <= vb_dly_d;
         rgb_q     <= rgb_d;
      end
   end

   assign RADDR        = raddr_q;
   assign HSYNC        = hs_dly_q[RD_LAT];
   assign VSYNC        = vs_dly_q[RD_LAT];
   assign DE           = act_dly_q[RD_LAT];
   assign VBLANK_START = vb_dly_q[RD_LAT];
   assign R            = rgb_q[8:6];
   assign G            = rgb_q[5:3];
   assign B            = rgb_q[2:0];
   assign FRAME_CNT    = frame_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout. Four instances share clock and reset:
//   0: full 640x480 timing, RD_LAT=1     1: full timing, RD_LAT=3
//   2: reduced timing holding a full 256x256 window, RD_LAT=3
//   3: tiny timing (96-cycle frame) for frame counter wrap, RD_LAT=1
// Each has a RAM model filled with random data. A reference model derives
// every pin from the cycle count since reset release; a table holds
// hand-derived spot values.
`timescale 1ns/1ps
module tb_fb_scanout;

   typedef struct {
      int ha, hfp, hs, hbp, va, vfp, vs, vbp, wx, wy, lat;
   } cfg_t;

   typedef struct {
      string       name;
      int          inst;
      int          cyc;
      int          sel;   // 0 HSYNC, 1 DE, 2 RADDR, 3 RGB, 4 VBLANK_START, 5 FRAME_CNT
      logic [15:0] exp;
   } vec_t;

`ifdef FB_BORDER_EN
   localparam logic [8:0] BORDER_EXP = 9'h1C0;
   logic [8:0] border = 9'h1C0;
`else
   localparam logic [8:0] BORDER_EXP = 9'h000;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] raddr [4];
   logic [8:0]  rdata [4];
   logic        hs [4];
   logic        vs [4];
   logic        de [4];
   logic        vb [4];
   logic [2:0]  r [4];
   logic [2:0]  g [4];
   logic [2:0]  b [4];
   logic [7:0]  fc [4];

   logic [8:0]  mem [65536];
   logic [8:0]  pipe [4][4];

   cfg_t        cfg [4];
   vec_t        tbl [$];
   int          n;
   int          last_addr [4];
   int          n_checks;
   int          n_fail;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   fb_scanout u_a (
      .CLK(clk), .RST(rst), .RADDR(raddr[0]), .RDATA(rdata[0]),
`ifdef FB_BORDER_EN
      .BORDER(border),
`endif
      .HSYNC(hs[0]), .VSYNC(vs[0]), .DE(de[0]), .R(r[0]), .G(g[0]), .B(b[0]),
      .VBLANK_START(vb[0]), .FRAME_CNT(fc[0]));

   fb_scanout #(.RD_LAT(3)) u_b (
      .CLK(clk), .RST(rst), .RADDR(raddr[1]), .RDATA(rdata[1]),
`ifdef FB_BORDER_EN
      .BORDER(border),
`endif
      .HSYNC(hs[1]), .VSYNC(vs[1]), .DE(de[1]), .R(r[1]), .G(g[1]), .B(b[1]),
      .VBLANK_START(vb[1]), .FRAME_CNT(fc[1]));

   fb_scanout #(.H_ACTIVE(258), .H_FP(1), .H_SYNC(1), .H_BP(2),
                .V_ACTIVE(257), .V_FP(1), .V_SYNC(1), .V_BP(1),
                .WIN_X0(1), .WIN_Y0(1), .RD_LAT(3)) u_c (
      .CLK(clk), .RST(rst), .RADDR(raddr[2]), .RDATA(rdata[2]),
`ifdef FB_BORDER_EN
      .BORDER(border),
`endif
      .HSYNC(hs[2]), .VSYNC(vs[2]), .DE(de[2]), .R(r[2]), .G(g[2]), .B(b[2]),
      .VBLANK_START(vb[2]), .FRAME_CNT(fc[2]));

   fb_scanout #(.H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
                .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
                .WIN_X0(2), .WIN_Y0(1), .RD_LAT(1)) u_d (
      .CLK(clk), .RST(rst), .RADDR(raddr[3]), .RDATA(rdata[3]),
`ifdef FB_BORDER_EN
      .BORDER(border),
`endif
      .HSYNC(hs[3]), .VSYNC(vs[3]), .DE(de[3]), .R(r[3]), .G(g[3]), .B(b[3]),
      .VBLANK_START(vb[3]), .FRAME_CNT(fc[3]));

   // Synchronous-read RAM models: RDATA is mem[RADDR] delayed RD_LAT edges.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         for (int k = 3; k > 0; k--) pipe[i][k] <= pipe[i][k-1];
         pipe[i][0] <= mem[raddr[i]];
      end
   end
   assign rdata[0] = pipe[0][0];
   assign rdata[1] = pipe[1][2];
   assign rdata[2] = pipe[2][2];
   assign rdata[3] = pipe[3][0];

   function automatic int ht_of(input int i);
      return cfg[i].ha + cfg[i].hfp + cfg[i].hs + cfg[i].hbp;
   endfunction

   function automatic int vt_of(input int i);
      return cfg[i].va + cfg[i].vfp + cfg[i].vs + cfg[i].vbp;
   endfunction

   function automatic bit in_win(input int i, input int h, input int v);
      return h < cfg[i].ha && v < cfg[i].va &&
             h >= cfg[i].wx && h < cfg[i].wx + 256 &&
             v >= cfg[i].wy && v < cfg[i].wy + 256;
   endfunction

   function automatic int addr_of(input int i, input int h, input int v);
      return (v - cfg[i].wy) * 256 + (h - cfg[i].wx);
   endfunction

   // Track the most recent window address the scan has reached.
   task automatic track_addr();
      for (int i = 0; i < 4; i++) begin
         int h, v;
         h = n % ht_of(i);
         v = (n / ht_of(i)) % vt_of(i);
         if (in_win(i, h, v)) last_addr[i] = addr_of(i, h, v);
      end
   endtask

   // Compare every pin of instance i against the model at cycle n.
   task automatic check_inst(input int i);
      int ht, vt, p, ph, pv;
      logic e_hs, e_vs, e_de, e_vb;
      logic [8:0] e_rgb;
      logic [7:0] e_fc;
      logic [36:0] got, exp;
      ht = ht_of(i);
      vt = vt_of(i);
      e_fc = 8'((n / (ht * vt)) % 256);
      p = n - (cfg[i].lat + 1);
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_vb = 1'b0; e_rgb = 9'd0;
      if (p >= 0) begin
         ph = p % ht;
         pv = (p / ht) % vt;
         e_de = ph < cfg[i].ha && pv < cfg[i].va;
         e_hs = !(ph >= cfg[i].ha + cfg[i].hfp && ph < cfg[i].ha + cfg[i].hfp + cfg[i].hs);
         e_vs = !(pv >= cfg[i].va + cfg[i].vfp && pv < cfg[i].va + cfg[i].vfp + cfg[i].vs);
         e_vb = ph == 0 && pv == cfg[i].va;
         if (in_win(i, ph, pv)) e_rgb = mem[addr_of(i, ph, pv)];
         else if (e_de) e_rgb = BORDER_EXP;
         else e_rgb = 9'd0;
      end
      got = {hs[i], vs[i], de[i], vb[i], r[i], g[i], b[i], raddr[i], fc[i]};
      exp = {e_hs, e_vs, e_de, e_vb, e_rgb, 16'(last_addr[i]), e_fc};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL pins inst%0d n=%0d got {hs,vs,de,vb,rgb,raddr,fc}=%h expected %h",
                  i, n, got, exp);
      end
   endtask

   // Apply table entries scheduled for the current cycle.
   task automatic check_table();
      for (int t = 0; t < tbl.size(); t++) begin
         if (tbl[t].cyc == n) begin
            logic [15:0] got;
            int i;
            i = tbl[t].inst;
            case (tbl[t].sel)
               0: got = {15'd0, hs[i]};
               1: got = {15'd0, de[i]};
               2: got = raddr[i];
               3: got = {7'd0, r[i], g[i], b[i]};
               4: got = {15'd0, vb[i]};
               5: got = {8'd0, fc[i]};
               default: got = 16'hDEAD;
            endcase
            n_checks++;
            if (got !== tbl[t].exp) begin
               n_fail++;
               $display("FAIL table %s n=%0d got %h expected %h", tbl[t].name, n, got, tbl[t].exp);
            end
         end
      end
   endtask

   task automatic reset_model();
      n = 0;
      for (int i = 0; i < 4; i++) last_addr[i] = 0;
   endtask

   initial begin
      int fall_at;
      logic prev_hs;
      n_checks = 0;
      n_fail   = 0;
      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 192, 112, 1};
      cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 192, 112, 3};
      cfg[2] = '{258, 1, 1, 2, 257, 1, 1, 1, 1, 1, 3};
      cfg[3] = '{6, 1, 2, 3, 4, 1, 1, 2, 2, 1, 1};
      for (int a = 0; a < 65536; a++) mem[a] = 9'($urandom);

      // Hand-derived spot values.
      tbl.push_back('{"a_hs_pre_fall", 0, 657, 0, 16'h0001});
      tbl.push_back('{"a_hs_fall",     0, 658, 0, 16'h0000});
      tbl.push_back('{"a_hs_last_low", 0, 753, 0, 16'h0000});
      tbl.push_back('{"a_hs_rise",     0, 754, 0, 16'h0001});
      tbl.push_back('{"a_hs_period",   0, 1458, 0, 16'h0000});
      tbl.push_back('{"a_de_before",   0, 1, 1, 16'h0000});
      tbl.push_back('{"a_de_first",    0, 2, 1, 16'h0001});
      tbl.push_back('{"a_de_last",     0, 641, 1, 16'h0001});
      tbl.push_back('{"a_de_off",      0, 642, 1, 16'h0000});
      tbl.push_back('{"b_hs_pre_fall", 1, 659, 0, 16'h0001});
      tbl.push_back('{"b_hs_fall",     1, 660, 0, 16'h0000});
      tbl.push_back('{"b_de_before",   1, 3, 1, 16'h0000});
      tbl.push_back('{"b_de_first",    1, 4, 1, 16'h0001});
      tbl.push_back('{"b_de_last",     1, 643, 1, 16'h0001});
      tbl.push_back('{"b_de_off",      1, 644, 1, 16'h0000});
      tbl.push_back('{"c_raddr_x1",    2, 264, 2, 16'h0001});
      tbl.push_back('{"c_raddr_xff",   2, 518, 2, 16'h00FF});
      tbl.push_back('{"c_raddr_hold",  2, 519, 2, 16'h00FF});
      tbl.push_back('{"c_raddr_y1",    2, 525, 2, 16'h0100});
      tbl.push_back('{"c_raddr_last",  2, 67328, 2, 16'hFFFF});
      tbl.push_back('{"c_raddr_past",  2, 67329, 2, 16'hFFFF});
      tbl.push_back('{"c_rgb_col0",    2, 266, 3, {7'd0, BORDER_EXP}});
      tbl.push_back('{"c_rgb_col257",  2, 523, 3, {7'd0, BORDER_EXP}});
      tbl.push_back('{"c_vb_pre",      2, 67337, 4, 16'h0000});
      tbl.push_back('{"c_vb_pulse",    2, 67338, 4, 16'h0001});
      tbl.push_back('{"c_vb_post",     2, 67339, 4, 16'h0000});
      tbl.push_back('{"d_vb_pulse",    3, 50, 4, 16'h0001});
      tbl.push_back('{"d_vb_post",     3, 51, 4, 16'h0000});
      tbl.push_back('{"d_fc_pre",      3, 95, 5, 16'h0000});
      tbl.push_back('{"d_fc_one",      3, 96, 5, 16'h0001});
      tbl.push_back('{"d_fc_255",      3, 24480, 5, 16'h00FF});
      tbl.push_back('{"d_fc_wrap",     3, 24576, 5, 16'h0000});

      // Reset held for 5 cycles: every pin at its reset value.
      rst = 1'b1;
      reset_model();
      repeat (5) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) check_inst(i);
      end

      // Long run from release; uA ends at (hcnt=300, vcnt=86).
      rst = 1'b0;
      for (int c = 1; c <= 69100; c++) begin
         @(negedge clk);
         n = c;
         track_addr();
         for (int i = 0; i < 4; i++) check_inst(i);
         check_table();
      end

      // Mid-frame asynchronous reset: pins drop with no clock edge.
      #2 rst = 1'b1;
      #1;
      reset_model();
      for (int i = 0; i < 4; i++) check_inst(i);
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) check_inst(i);
      end

      // Release and measure the next HSYNC fall on uA (bounded).
      rst = 1'b0;
      fall_at = -1;
      prev_hs = hs[0];
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         n = c;
         track_addr();
         for (int i = 0; i < 4; i++) check_inst(i);
         if (fall_at < 0 && prev_hs && !hs[0]) fall_at = c;
         prev_hs = hs[0];
      end
      n_checks++;
      if (fall_at != 658) begin
         n_fail++;
         $display("FAIL hs_fall_after_rst got %0d expected 658 (-1 = no falling edge)", fall_at);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
